// File: rtl/asr_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : asr_bank                                                   |
// | Description : Ancillary state register bank serving RDASR/WRASR. A       |
// |               window of FIRST_ASR..FIRST_ASR+NUM_ASR-1 is implemented;   |
// |               any other select reads 0, drops writes and flags asr_err.  |
// |               Optional macro ASR_TIMER_EN turns window indices 0..2 into |
// |               an interval timer (COUNT, CMP, CTRL) with an IRQ output.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module asr_bank #(
  parameter int WIDTH     = 32,
  parameter int FIRST_ASR = 16,
  parameter int NUM_ASR   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             asr_rd,
  input  logic             asr_wr,
  input  logic [4:0]       asr_sel,
  input  logic [WIDTH-1:0] asr_in,
  output logic [WIDTH-1:0] asr_out,
  output logic             asr_err,
  output logic             timer_irq
);

  // Window bounds widened to 6 bits so that FIRST_ASR+NUM_ASR == 32 fits.
  localparam logic [5:0] c_LO = 6'(FIRST_ASR);
  localparam logic [5:0] c_HI = 6'(FIRST_ASR + NUM_ASR);

`ifdef ASR_TIMER_EN
  localparam int c_GEN_BASE = 3;
`else
  localparam int c_GEN_BASE = 0;
`endif

  logic [5:0]       w_sel;
  logic [5:0]       w_idx;
  logic             w_hit;
  logic [NUM_ASR-1:0] w_wr;
  logic [WIDTH-1:0] w_rd [NUM_ASR];
  logic             r_err;

  assign w_sel = {1'b0, asr_sel};
  assign w_hit = (w_sel >= c_LO) && (w_sel < c_HI);
  assign w_idx = w_sel - c_LO;

  // Select decode: per-register write enables and the zero-latency read mux.
  always_comb begin
    w_wr    = '0;
    asr_out = '0;
    for (int i = 0; i < NUM_ASR; i++) begin
      if (w_hit && (w_idx == 6'(i))) begin
        w_wr[i] = asr_wr;
        asr_out = w_rd[i];
      end
    end
  end

  // One-cycle error pulse for any strobed access outside the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= (asr_rd | asr_wr) & ~w_hit;
  end

  assign asr_err = r_err;

  // Plain general-purpose registers (all indices not claimed by the timer).
  generate
    for (genvar gi = c_GEN_BASE; gi < NUM_ASR; gi++) begin : g_gen
      logic [WIDTH-1:0] r_q;

      // Load on a write strobe to this index, hold otherwise.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_q <= '0;
        else if (w_wr[gi]) r_q <= asr_in;
      end

      assign w_rd[gi] = r_q;
    end
  endgenerate

`ifdef ASR_TIMER_EN
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_cmp;
  logic             r_en;
  logic             r_reload;
  logic             r_ie;
  logic             r_pend;
  logic             w_match;

  // A software write to COUNT suppresses the compare for that cycle.
  assign w_match = r_en & ~w_wr[0] & (r_count == r_cmp);

  // COUNT: software write wins, else increment (or reload to 0 on a match).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_count <= '0;
    else if (w_wr[0])             r_count <= asr_in;
    else if (w_match && r_reload) r_count <= '0;
    else if (r_en)                r_count <= r_count + 1'b1;
  end

  // CMP: plain software-loaded compare value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_cmp <= '0;
    else if (w_wr[1]) r_cmp <= asr_in;
  end

  // CTRL: EN/RELOAD/IE load from software; PEND is set by a match and
  // cleared by writing 1 to bit 3, with the hardware set taking priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en     <= 1'b0;
      r_reload <= 1'b0;
      r_ie     <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      if (w_wr[2]) begin
        r_en     <= asr_in[0];
        r_reload <= asr_in[1];
        r_ie     <= asr_in[2];
      end
      if (w_match)                  r_pend <= 1'b1;
      else if (w_wr[2] && asr_in[3]) r_pend <= 1'b0;
    end
  end

  assign w_rd[0]   = r_count;
  assign w_rd[1]   = r_cmp;
  assign w_rd[2]   = {{(WIDTH-4){1'b0}}, r_pend, r_ie, r_reload, r_en};
  assign timer_irq = r_pend & r_ie;
`else
  assign timer_irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_asr_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_asr_bank                                                |
// | Description : Self-checking bench for asr_bank: vector table, directed   |
// |               timer sequences and random traffic against a model.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_asr_bank;

  localparam int W     = 32;
  localparam int FIRST = 16;
  localparam int NUM   = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         asr_rd;
  logic         asr_wr;
  logic [4:0]   asr_sel;
  logic [W-1:0] asr_in;
  logic [W-1:0] asr_out;
  logic         asr_err;
  logic         timer_irq;

  asr_bank #(.WIDTH(W), .FIRST_ASR(FIRST), .NUM_ASR(NUM)) dut (
    .clk       (clk),
    .rst       (rst),
    .asr_rd    (asr_rd),
    .asr_wr    (asr_wr),
    .asr_sel   (asr_sel),
    .asr_in    (asr_in),
    .asr_out   (asr_out),
    .asr_err   (asr_err),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state indexed by ASR number; COUNT/CMP live at FIRST/FIRST+1.
  logic [31:0] m_reg [32];
  bit m_en, m_rl, m_ie, m_pend, m_err;

  logic [31:0] obs_out;
  logic        obs_err;
  logic        obs_irq;

  typedef struct {
    bit          rd;
    bit          wr;
    int          sel;
    logic [31:0] din;
    logic [31:0] exp_out;
    bit          exp_err;
  } vec_t;

  function automatic bit implemented(int s);
    return (s >= FIRST) && (s < FIRST + NUM);
  endfunction

  function automatic logic [31:0] model_read(int s);
    if (!implemented(s)) return 32'h0;
`ifdef ASR_TIMER_EN
    if (s == FIRST + 2) return {28'h0, m_pend, m_ie, m_rl, m_en};
`endif
    return m_reg[s];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_en = 0; m_rl = 0; m_ie = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic model_clock(input bit rd, input bit wr, input int sel, input logic [31:0] din);
    bit hit;
    hit = implemented(sel);
`ifdef ASR_TIMER_EN
    begin
      logic [31:0] cnt;
      bit wcnt, wctl, match;
      cnt   = m_reg[FIRST];
      wcnt  = wr && (sel == FIRST);
      wctl  = wr && (sel == FIRST + 2);
      match = m_en && !wcnt && (cnt == m_reg[FIRST+1]);
      if (wr && hit && sel != FIRST && sel != FIRST + 2) m_reg[sel] = din;
      if (wcnt)      m_reg[FIRST] = din;
      else if (m_en) m_reg[FIRST] = (match && m_rl) ? 32'h0 : cnt + 32'h1;
      if (match)             m_pend = 1;
      else if (wctl && din[3]) m_pend = 0;
      if (wctl) begin
        m_en = din[0]; m_rl = din[1]; m_ie = din[2];
      end
    end
`else
    if (wr && hit) m_reg[sel] = din;
`endif
    m_err = (rd || wr) && !hit;
  endtask

  // One bus cycle: apply inputs, check outputs mid-cycle, clock the model.
  task automatic step(input bit rd, input bit wr, input int sel, input logic [31:0] din);
    asr_rd  = rd;
    asr_wr  = wr;
    asr_sel = 5'(sel);
    asr_in  = din;
    @(negedge clk);
    obs_out = asr_out;
    obs_err = asr_err;
    obs_irq = timer_irq;
    chk("out", obs_out, model_read(sel));
    chk("err", {31'h0, obs_err}, {31'h0, m_err});
    chk("irq", {31'h0, obs_irq}, {31'h0, m_pend & m_ie});
    @(posedge clk);
    model_clock(rd, wr, sel, din);
    #1;
  endtask

  vec_t vt [11];
  logic [31:0] seq [12];
  logic        irqs [12];

  initial begin
    rst = 1'b0; asr_rd = 0; asr_wr = 0; asr_sel = 0; asr_in = 0;
    model_reset();

    // Reset: every select reads 0.
    #3;
    for (int s = 0; s < 32; s++) begin
      asr_sel = 5'(s);
      #1;
      chk("rst_out", asr_out, 32'h0);
    end
    chk("rst_err", {31'h0, asr_err}, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Register-file vectors (asr_err reflects the previous row's access).
    vt[0]  = '{0, 1, 20, 32'hDEADBEEF, 32'h0,        0};
    vt[1]  = '{0, 1, 31, 32'h12345678, 32'h0,        0};
    vt[2]  = '{1, 0, 20, 32'h0,        32'hDEADBEEF, 0};
    vt[3]  = '{1, 0, 31, 32'h0,        32'h12345678, 0};
    vt[4]  = '{0, 1, 5,  32'h0000AAAA, 32'h0,        0};
    vt[5]  = '{1, 0, 5,  32'h0,        32'h0,        1};
    vt[6]  = '{0, 0, 20, 32'h0,        32'hDEADBEEF, 1};
    vt[7]  = '{0, 0, 0,  32'h0,        32'h0,        0};
    vt[8]  = '{1, 0, 15, 32'h0,        32'h0,        0};
    vt[9]  = '{0, 1, 19, 32'h00000F0F, 32'h0,        1};
    vt[10] = '{1, 0, 19, 32'h0,        32'h00000F0F, 0};
    for (int i = 0; i < 11; i++) begin
      step(vt[i].rd, vt[i].wr, vt[i].sel, vt[i].din);
      chk($sformatf("vec%0d_out", i), obs_out, vt[i].exp_out);
      chk($sformatf("vec%0d_err", i), {31'h0, obs_err}, {31'h0, vt[i].exp_err});
    end

`ifdef ASR_TIMER_EN
    // Compare match without reload.
    step(0, 1, FIRST + 1, 32'd10);
    step(0, 1, FIRST + 2, 32'h5);
    for (int k = 0; k < 12; k++) begin
      step(0, 0, FIRST, 32'h0);
      seq[k] = obs_out; irqs[k] = obs_irq;
    end
    chk("cnt_first", seq[0], 32'd0);
    chk("cnt10", seq[10], 32'd10);
    chk("irq_before", {31'h0, irqs[10]}, 32'h0);
    chk("cnt11", seq[11], 32'd11);
    chk("irq_after", {31'h0, irqs[11]}, 32'h1);
    step(0, 1, FIRST + 2, 32'h8);
    step(0, 0, FIRST + 2, 32'h0);
    chk("w1c_clear", obs_out, 32'h0);

    // Reload mode.
    step(0, 1, FIRST, 32'h0);
    step(0, 1, FIRST + 1, 32'd3);
    step(0, 1, FIRST + 2, 32'h7);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, FIRST, 32'h0);
      seq[k] = obs_out; irqs[k] = obs_irq;
    end
    for (int k = 0; k < 8; k++) chk($sformatf("reload%0d", k), seq[k], 32'(k % 4));
    chk("rl_irq3", {31'h0, irqs[3]}, 32'h0);
    chk("rl_irq4", {31'h0, irqs[4]}, 32'h1);

    // W1C on a match cycle: set wins.
    for (int k = 0; k < 8 && m_reg[FIRST] != 32'd3; k++) step(0, 0, FIRST, 32'h0);
    chk("reach3", m_reg[FIRST], 32'd3);
    step(0, 1, FIRST + 2, 32'hF);
    step(0, 0, FIRST + 2, 32'h0);
    chk("w1c_match", obs_out, 32'hF);
    // W1C away from a match clears.
    for (int k = 0; k < 8 && m_reg[FIRST] != 32'd1; k++) step(0, 0, FIRST, 32'h0);
    step(0, 1, FIRST + 2, 32'hF);
    step(0, 0, FIRST + 2, 32'h0);
    chk("w1c_nomatch", obs_out, 32'h7);

    // Wrap from all-ones to zero, then match at CMP=0.
    step(0, 1, FIRST + 2, 32'h8);
    step(0, 1, FIRST + 1, 32'h0);
    step(0, 1, FIRST, 32'hFFFFFFFF);
    step(0, 1, FIRST + 2, 32'h1);
    step(0, 0, FIRST, 32'h0);
    chk("wrap_ff", obs_out, 32'hFFFFFFFF);
    step(0, 0, FIRST, 32'h0);
    chk("wrap_0", obs_out, 32'h0);
    step(0, 0, FIRST, 32'h0);
    chk("wrap_1", obs_out, 32'h1);
    step(0, 0, FIRST + 2, 32'h0);
    chk("wrap_pend", obs_out, 32'h9);
`else
    // Without the timer, indices 0..2 are plain storage.
    step(0, 1, FIRST,     32'hA5A5_0001);
    step(0, 1, FIRST + 1, 32'h5A5A_0002);
    step(0, 1, FIRST + 2, 32'hFFFF_FFFF);
    step(0, 0, FIRST, 32'h0);
    chk("plain0", obs_out, 32'hA5A5_0001);
    step(0, 0, FIRST + 1, 32'h0);
    chk("plain1", obs_out, 32'h5A5A_0002);
    step(0, 0, FIRST + 2, 32'h0);
    chk("plain2", obs_out, 32'hFFFF_FFFF);
    step(0, 0, FIRST, 32'h0);
    chk("no_count", obs_out, 32'hA5A5_0001);
    chk("no_irq", {31'h0, obs_irq}, 32'h0);
`endif

    // Random traffic biased toward the timer window and the boundaries.
    for (int n = 0; n < 400; n++) begin
      int sel;
      bit rd, wr;
      logic [31:0] din;
      sel = ($urandom_range(0, 9) < 7) ? FIRST + int'($urandom_range(0, 4)) : int'($urandom_range(0, 31));
      rd  = ($urandom_range(0, 3) == 0);
      wr  = ($urandom_range(0, 3) == 0);
      if (sel == FIRST + 2)                     din = $urandom_range(0, 15);
      else if (sel == FIRST || sel == FIRST + 1) din = $urandom_range(0, 40);
      else                                       din = $urandom;
      step(rd, wr, sel, din);
    end

`ifdef ASR_TIMER_EN
    step(0, 1, FIRST + 2, 32'h5);
    for (int k = 0; k < 4; k++) step(0, 0, FIRST, 32'h0);
`endif
    // Asynchronous reset mid-count.
    asr_sel = 5'(FIRST);
    rst = 1'b0;
    #1;
    chk("mid_rst_cnt", asr_out, 32'h0);
    chk("mid_rst_irq", {31'h0, timer_irq}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) step(0, 0, FIRST, 32'h0);
    chk("post_rst_hold", obs_out, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
